// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Grants one byte at a time, runs the txStart/txBusy handshake with a start timeout,
// and reports per-byte completion or abort tagged with the owning requester.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 4096,
  parameter int unsigned ID_W          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic                 txEn,
  output logic                 txStart,
  output logic [7:0]           txIn,
  input  logic                 txBusy,
  input  logic                 txDone,
  output logic [ID_W-1:0]      grantId,
  output logic                 active,
  output logic                 sentPulse,
  output logic                 abortPulse
);

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]        tx_in_q, tx_in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sent_q, sent_d;
  logic              abort_q, abort_d;
  logic              found;
  logic [ID_W-1:0]   winner;
  int unsigned       idx;

  // Find the first valid requester starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && reqValid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Next-state logic: grant, start handshake with timeout, wait for completion.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    tx_in_d    = tx_in_q;
    cnt_d      = cnt_q;
    sent_d     = 1'b0;
    abort_d    = 1'b0;
    reqReady   = '0;
    unique case (state_q)
      StIdle: begin
        // Reset gating keeps the combinational accept pulse quiet while reset is held.
        if (enable && found && !reset) begin
          reqReady[winner] = 1'b1;
          grant_id_d       = winner;
          tx_in_d          = reqData[{winner, 3'b000} +: 8];
          ptr_d            = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          cnt_d            = '0;
          state_d          = StStart;
        end
      end
      StStart: begin
        // txBusy takes priority over a timeout landing in the same cycle.
        if (txBusy) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (enable) begin
          if (cnt_q >= CNT_W'(START_TIMEOUT - 1)) begin
            abort_d = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWaitDone: begin
        if (txDone && !txBusy) begin
          sent_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_id_q <= '0;
      tx_in_q    <= '0;
      cnt_q      <= '0;
      sent_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_in_q    <= tx_in_d;
      cnt_q      <= cnt_d;
      sent_q     <= sent_d;
      abort_q    <= abort_d;
    end
  end

  // Output decode.
  always_comb begin
    txEn       = enable;
    txStart    = (state_q == StStart);
    active     = (state_q != StIdle);
    txIn       = tx_in_q;
    grantId    = grant_id_q;
    sentPulse  = sent_q;
    abortPulse = abort_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a transaction-level reference model,
// a few hand-computed directed checks, and a 3-requester instance for wrap order.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [3:0]  req_ready;
  logic        tx_en, tx_start, active, sent_pulse, abort_pulse;
  logic [7:0]  tx_in;
  logic [1:0]  grant_id;

  logic        enable3 = 1'b0;
  logic [2:0]  valid3 = '0;
  logic [23:0] data3 = 24'h33_22_11;
  logic        busy3 = 1'b0;
  logic        done3 = 1'b0;
  logic [2:0]  ready3;
  logic        tx_en3, tx_start3, active3, sent3, abort3;
  logic [7:0]  tx_in3;
  logic [1:0]  grant_id3;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one outstanding transaction, described by flags and counters.
  bit         m_have, m_started, m_sent, m_abort, u_dead;
  int         m_wait, m_ptr, m_gid;
  logic [7:0] m_byte;
  logic [3:0] m_last_ready;

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .reqValid(req_valid), .reqData(req_data),
    .reqReady(req_ready), .txEn(tx_en), .txStart(tx_start), .txIn(tx_in),
    .txBusy(tx_busy), .txDone(tx_done), .grantId(grant_id), .active(active),
    .sentPulse(sent_pulse), .abortPulse(abort_pulse)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .START_TIMEOUT(TO)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .reqValid(valid3), .reqData(data3),
    .reqReady(ready3), .txEn(tx_en3), .txStart(tx_start3), .txIn(tx_in3),
    .txBusy(busy3), .txDone(done3), .grantId(grant_id3), .active(active3),
    .sentPulse(sent3), .abortPulse(abort3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_started = 0; m_sent = 0; m_abort = 0;
    m_wait = 0; m_ptr = 0; m_gid = 0; m_byte = 8'h00;
  endtask

  // Compare every output against the model for the current cycle, then advance the model
  // across the coming rising edge and return at the following falling edge.
  task automatic tick();
    int w;
    logic [3:0] exp_ready;
    bit nxt_sent, nxt_abort;
    #1;
    if (reset) model_reset();
    w = -1;
    if (!reset && !m_have && enable) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("req_ready",   32'(req_ready),   32'(exp_ready));
    chk("tx_en",       32'(tx_en),       32'(enable));
    chk("tx_start",    32'(tx_start),    32'(m_have && !m_started));
    chk("active",      32'(active),      32'(m_have));
    chk("grant_id",    32'(grant_id),    32'(m_gid));
    chk("tx_in",       32'(tx_in),       32'(m_byte));
    chk("sent_pulse",  32'(sent_pulse),  32'(m_sent));
    chk("abort_pulse", 32'(abort_pulse), 32'(m_abort));
    m_last_ready = exp_ready;
    if (!reset) begin
      nxt_sent = 0;
      nxt_abort = 0;
      if (w >= 0) begin
        m_have = 1; m_started = 0; m_wait = 0;
        m_gid = w; m_byte = req_data[8*w +: 8]; m_ptr = (w + 1) % N;
        u_dead = ($urandom_range(0, 3) == 0);
      end else if (m_have && !m_started) begin
        if (tx_busy) m_started = 1;
        else if (enable) begin
          m_wait++;
          if (m_wait == TO) begin m_have = 0; nxt_abort = 1; end
        end
      end else if (m_have && m_started && tx_done && !tx_busy) begin
        m_have = 0; nxt_sent = 1;
      end
      m_sent = nxt_sent;
      m_abort = nxt_abort;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_cnt, g, g3;
    bit seen;
    model_reset();
    m_last_ready = '0;
    u_dead = 0;

    // Reset values, txEn follows enable even in reset.
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_txin", 32'(tx_in), 0);
    chk("rst_pulses", 32'({sent_pulse, abort_pulse}), 0);
    chk("rst_txen0", 32'(tx_en), 0);
    enable = 1'b1;
    #1;
    chk("rst_txen1", 32'(tx_en), 1);
    tick();

    // Single byte from requester 2.
    reset = 1'b0;
    req_valid = 4'b0100;
    req_data[23:16] = 8'h8A;
    #1 chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_start", 32'(tx_start), 1);
    chk("single_gid", 32'(grant_id), 2);
    chk("single_txin", 32'(tx_in), 32'h8A);
    tick();
    tx_busy = 1'b1;
    tick();
    tx_done = 1'b1;
    #1 chk("single_start_low", 32'(tx_start), 0);
    tick();
    tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
    #1 chk("single_sent", 32'(sent_pulse), 1);
    tick();

    // Start timeout: txBusy never rises; one stale txDone in START is ignored.
    req_valid = 4'b0001;
    req_data[7:0] = 8'h55;
    tick();
    req_valid = 4'b0000;
    t_cnt = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tx_done = (c == 3);
      #1;
      if (abort_pulse) begin
        seen = 1;
        tick();
        break;
      end
      if (tx_start) t_cnt++;
      tick();
    end
    tx_done = 1'b0;
    chk("timeout_seen", 32'(seen), 1);
    chk("timeout_cycles", 32'(t_cnt), TO);

    // Blocked by enable=0, then released.
    enable = 1'b0;
    req_valid = 4'b1000;
    req_data[31:24] = 8'h7A;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("blocked_ready", 32'(req_ready), 0);
      chk("blocked_active", 32'(active), 0);
      tick();
    end
    enable = 1'b1;
    #1 chk("release_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    tx_busy = 1'b1;
    #1 chk("release_txin", 32'(tx_in), 32'h7A);
    tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1 chk("release_sent", 32'(sent_pulse), 1);
    tick();

    // Reset in WAIT_DONE: immediate reset values, no pulse, pointer back to 0.
    req_valid = 4'b0010;
    req_data[15:8] = 8'h3C;
    tick();
    req_valid = 4'b0000;
    tx_busy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_active", 32'(active), 0);
    chk("midrst_txin", 32'(tx_in), 0);
    chk("midrst_gid", 32'(grant_id), 0);
    tick();
    reset = 1'b0;
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    req_valid = 4'b1111;
    req_data = 32'h44_33_22_11;
    #1;
    chk("midrst_nosent", 32'(sent_pulse), 0);
    chk("midrst_ptr0", 32'(req_ready), 32'h1);
    tick();

    // Fairness: all requesters valid continuously; grants continue from 1.
    g = 0;
    for (int c = 0; c < 100 && g < 8; c++) begin
      tx_busy = m_have && !m_started;
      tx_done = m_have && m_started;
      #1;
      if (req_ready != 4'b0000) begin
        chk("fair_order", 32'(req_ready), 32'(1 << ((g + 1) % 4)));
        g++;
      end
      tick();
    end
    chk("fair_grants", 32'(g), 8);
    req_valid = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      tx_busy = m_have && !m_started;
      tx_done = m_have && m_started;
      tick();
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_last_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      enable = ($urandom_range(0, 7) != 0);
      tx_busy = m_have && !u_dead && ($urandom_range(0, 2) == 0);
      tx_done = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 1'b0;

    // Three requesters: order must wrap 0,1,2,0,1,2.
    enable3 = 1'b1;
    valid3 = 3'b111;
    g3 = 0;
    for (int c = 0; c < 100 && g3 < 6; c++) begin
      busy3 = active3 && tx_start3;
      done3 = active3 && !tx_start3;
      #1;
      if (ready3 != 3'b000) begin
        chk("odd_order", 32'(ready3), 32'(1 << (g3 % 3)));
        g3++;
      end
      @(negedge clk);
    end
    chk("odd_grants", 32'(g3), 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
